// File: rtl/ibex_rf_write_sequencer.sv
// Register file write-port front end: post-reset init sweep, then merges writeback
// requests with buffered load returns and exposes pending writes for forwarding.
module ibex_rf_write_sequencer #(
    parameter bit                   RV32E       = 1'b0,
    parameter int unsigned          DataWidth   = 32,
    parameter logic [DataWidth-1:0] ResetVal    = '0,
    parameter int unsigned          FifoDepth   = 2,
    parameter int unsigned          StarveLimit = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 wb_valid_i,
    input  logic [4:0]           wb_addr_i,
    input  logic [DataWidth-1:0] wb_data_i,
    output logic                 wb_ready_o,
    input  logic                 lsu_valid_i,
    input  logic [4:0]           lsu_addr_i,
    input  logic [DataWidth-1:0] lsu_data_i,
    output logic                 lsu_ready_o,
    output logic [4:0]           waddr_a_o,
    output logic [DataWidth-1:0] wdata_a_o,
    output logic                 we_a_o,
    input  logic [4:0]           raddr_a_i,
    input  logic [4:0]           raddr_b_i,
    output logic                 fwd_a_valid_o,
    output logic                 fwd_b_valid_o,
    output logic [DataWidth-1:0] fwd_a_data_o,
    output logic [DataWidth-1:0] fwd_b_data_o,
    output logic                 init_done_o,
    output logic                 err_o
);
    localparam int unsigned    NumRegs = RV32E ? 16 : 32;
    localparam int unsigned    SW      = $clog2(StarveLimit + 1);
    localparam logic [4:0]     LastReg = 5'(NumRegs - 1);
    localparam logic [1:0]     LastIdx = 2'(FifoDepth - 1);
    localparam logic [2:0]     Depth   = 3'(FifoDepth);
    localparam logic [SW-1:0]  Limit   = SW'(StarveLimit);

    typedef enum logic {S_INIT, S_RUN} state_e;

    state_e               r_state, w_state_nxt;
    logic [4:0]           r_ptr;
    logic [4:0]           r_fifo_addr [4];
    logic [DataWidth-1:0] r_fifo_data [4];
    logic [1:0]           r_head, r_tail;
    logic [2:0]           r_count;
    logic [SW-1:0]        r_starve;
    logic [4:0]           r_waddr;
    logic [DataWidth-1:0] r_wdata;
    logic                 r_we, r_err;

    logic w_run, w_empty, w_full, w_starve, w_wb_ready, w_lsu_ready;
    logic w_wb_take, w_lsu_take, w_wb_bad, w_lsu_bad, w_pop, w_bypass, w_push;
    logic [4:0]           w_head_addr, w_ld_addr;
    logic [DataWidth-1:0] w_head_data, w_ld_data;
    logic                 w_ld_we, w_err_nxt;

    function automatic logic [1:0] f_inc(input logic [1:0] p);
        return (p == LastIdx) ? 2'd0 : p + 2'd1;
    endfunction

    assign w_run       = (r_state == S_RUN);
    assign w_empty     = (r_count == 3'd0);
    assign w_full      = (r_count == Depth);
    assign w_starve    = w_run && !w_empty && (r_starve == Limit);
    assign w_wb_ready  = w_run && !w_starve;
    assign w_lsu_ready = w_run && !w_full;
    assign w_wb_take   = wb_valid_i && w_wb_ready;
    assign w_lsu_take  = lsu_valid_i && w_lsu_ready;
    assign w_wb_bad    = RV32E && wb_addr_i[4];
    assign w_lsu_bad   = RV32E && lsu_addr_i[4];
    assign w_pop       = w_run && !w_wb_take && !w_empty;
    // An idle cycle with an empty FIFO lets a load return go straight to the write port.
    assign w_bypass    = w_run && !w_wb_take && w_empty && w_lsu_take;
    assign w_push      = w_lsu_take && !w_lsu_bad && !w_bypass;
    assign w_head_addr = r_fifo_addr[r_head];
    assign w_head_data = r_fifo_data[r_head];

    always_comb begin
        w_state_nxt = r_state;
        w_ld_addr   = '0;
        w_ld_data   = '0;
        w_ld_we     = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            S_INIT: begin
                w_ld_addr = r_ptr;
                w_ld_data = ResetVal;
                w_ld_we   = 1'b1;
                if (r_ptr == LastReg) w_state_nxt = S_RUN;
            end
            default: begin
                if (w_wb_take) begin
                    w_ld_addr = wb_addr_i;
                    w_ld_data = wb_data_i;
                    w_ld_we   = !w_wb_bad && (wb_addr_i != 5'd0);
                end else if (w_pop) begin
                    w_ld_addr = w_head_addr;
                    w_ld_data = w_head_data;
                    w_ld_we   = (w_head_addr != 5'd0);
                end else if (w_bypass) begin
                    w_ld_addr = lsu_addr_i;
                    w_ld_data = lsu_data_i;
                    w_ld_we   = !w_lsu_bad && (lsu_addr_i != 5'd0);
                end
                w_err_nxt = (w_wb_take && w_wb_bad) || (w_lsu_take && w_lsu_bad);
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= S_INIT;
            r_ptr    <= 5'd1;
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
            r_starve <= '0;
            r_waddr  <= '0;
            r_wdata  <= '0;
            r_we     <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (!w_run) r_ptr <= r_ptr + 5'd1;
            r_waddr <= w_ld_addr;
            r_wdata <= w_ld_data;
            r_we    <= w_ld_we;
            r_err   <= w_err_nxt;
            if (w_push) r_tail <= f_inc(r_tail);
            if (w_pop)  r_head <= f_inc(r_head);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
            if (w_pop || w_empty)  r_starve <= '0;
            else if (w_wb_take)    r_starve <= r_starve + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo_addr[r_tail] <= lsu_addr_i;
            r_fifo_data[r_tail] <= lsu_data_i;
        end
    end

    // Output stage is the oldest pending write; FIFO entries are scanned oldest to
    // youngest so the last hit (youngest) wins.
    always_comb begin
        logic [2:0] sum;
        logic [1:0] idx;
        sum           = '0;
        idx           = '0;
        fwd_a_valid_o = r_we && (r_waddr == raddr_a_i) && (raddr_a_i != 5'd0);
        fwd_b_valid_o = r_we && (r_waddr == raddr_b_i) && (raddr_b_i != 5'd0);
        fwd_a_data_o  = fwd_a_valid_o ? r_wdata : '0;
        fwd_b_data_o  = fwd_b_valid_o ? r_wdata : '0;
        for (int i = 0; i < int'(FifoDepth); i++) begin
            sum = {1'b0, r_head} + 3'(i);
            if (sum >= Depth) sum = sum - Depth;
            idx = sum[1:0];
            if (3'(i) < r_count) begin
                if ((r_fifo_addr[idx] == raddr_a_i) && (raddr_a_i != 5'd0)) begin
                    fwd_a_valid_o = 1'b1;
                    fwd_a_data_o  = r_fifo_data[idx];
                end
                if ((r_fifo_addr[idx] == raddr_b_i) && (raddr_b_i != 5'd0)) begin
                    fwd_b_valid_o = 1'b1;
                    fwd_b_data_o  = r_fifo_data[idx];
                end
            end
        end
    end

    assign wb_ready_o  = w_wb_ready;
    assign lsu_ready_o = w_lsu_ready;
    assign waddr_a_o   = r_waddr;
    assign wdata_a_o   = r_wdata;
    assign we_a_o      = r_we;
    assign init_done_o = w_run;
    assign err_o       = r_err;
endmodule
